// File: rtl/food_placer.sv
// Food placement for a grid snake game: LFSR candidates, occupancy query handshake,
// eat / refresh detection and retry-exhaustion signalling.
module food_placer #(
   parameter int REFRESH_TICKS = 200,
   parameter int MAX_RETRY     = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] state,
   input  logic       tick,
   input  logic [5:0] head_x,
   input  logic [5:0] head_y,
   output logic       occ_req,
   output logic [5:0] occ_x,
   output logic [5:0] occ_y,
   input  logic       occ_ack,
   input  logic       occ_hit,
   output logic [5:0] food_x,
   output logic [5:0] food_y,
   output logic       food_valid,
   output logic       grow,
   output logic       place_fail
);

   localparam int CW = $clog2(REFRESH_TICKS + 1);
   localparam int RW = $clog2(MAX_RETRY + 1);

   typedef enum logic [1:0] {IDLE, GEN, QUERY, COMMIT} fsm_t;

   fsm_t          fsm_q, fsm_d;
   logic [15:0]   lfsr_q, lfsr_d;
   logic [CW-1:0] refresh_q, refresh_d;
   logic [RW-1:0] retry_q, retry_d;
   logic          play_prev_q, play_prev_d;
   logic          occ_req_q, occ_req_d;
   logic [5:0]    occ_x_q, occ_x_d, occ_y_q, occ_y_d;
   logic [5:0]    food_x_q, food_x_d, food_y_q, food_y_d;
   logic          food_valid_q, food_valid_d;
   logic          grow_q, grow_d;
   logic          place_fail_q, place_fail_d;

   logic          playing;
   logic          reject;
   logic [5:0]    cand_x, cand_y;

   assign playing = (state == 2'b01);
   // Offsets of one keep candidates off the wall ring at row/column 0.
   assign cand_x  = (lfsr_q[5:0] % 6'd38) + 6'd1;
   assign cand_y  = (lfsr_q[11:6] % 6'd28) + 6'd1;

   always_comb begin
      fsm_d        = fsm_q;
      lfsr_d       = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      refresh_d    = refresh_q;
      retry_d      = retry_q;
      play_prev_d  = playing;
      occ_req_d    = occ_req_q;
      occ_x_d      = occ_x_q;
      occ_y_d      = occ_y_q;
      food_x_d     = food_x_q;
      food_y_d     = food_y_q;
      food_valid_d = food_valid_q;
      grow_d       = 1'b0;
      place_fail_d = 1'b0;
      reject       = 1'b0;

      if (!playing) begin
         fsm_d        = IDLE;
         occ_req_d    = 1'b0;
         food_x_d     = 6'd10;
         food_y_d     = 6'd20;
         food_valid_d = 1'b0;
         refresh_d    = '0;
         retry_d      = '0;
      end else begin
         case (fsm_q)
            IDLE: begin
               if (!play_prev_q) begin
                  fsm_d = GEN;
               end else if (tick) begin
                  if (refresh_q == CW'(REFRESH_TICKS - 1)) begin
                     refresh_d    = '0;
                     food_valid_d = 1'b0;
                     fsm_d        = GEN;
                  end else begin
                     refresh_d = refresh_q + CW'(1);
                  end
               end
            end
            GEN: begin
               occ_x_d = cand_x;
               occ_y_d = cand_y;
               if (cand_x == head_x && cand_y == head_y) begin
                  reject = 1'b1;
               end else begin
                  occ_req_d = 1'b1;
                  fsm_d     = QUERY;
               end
            end
            QUERY: begin
               if (occ_ack) begin
                  occ_req_d = 1'b0;
                  if (occ_hit) begin
                     reject = 1'b1;
                     fsm_d  = GEN;
                  end else begin
                     fsm_d = COMMIT;
                  end
               end
            end
            COMMIT: begin
               food_x_d     = occ_x_q;
               food_y_d     = occ_y_q;
               food_valid_d = 1'b1;
               retry_d      = '0;
               refresh_d    = '0;
               fsm_d        = IDLE;
            end
            default: fsm_d = IDLE;
         endcase

         if (reject) begin
            if (retry_q == RW'(MAX_RETRY - 1)) begin
               place_fail_d = 1'b1;
               retry_d      = '0;
            end else begin
               retry_d = retry_q + RW'(1);
            end
         end

         // Eating overrides a refresh landing on the same cycle.
         if (food_valid_q && head_x == food_x_q && head_y == food_y_q) begin
            grow_d       = 1'b1;
            food_valid_d = 1'b0;
            refresh_d    = '0;
            fsm_d        = GEN;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fsm_q        <= IDLE;
         lfsr_q       <= 16'hACE1;
         refresh_q    <= '0;
         retry_q      <= '0;
         play_prev_q  <= 1'b0;
         occ_req_q    <= 1'b0;
         occ_x_q      <= '0;
         occ_y_q      <= '0;
         food_x_q     <= 6'd10;
         food_y_q     <= 6'd20;
         food_valid_q <= 1'b0;
         grow_q       <= 1'b0;
         place_fail_q <= 1'b0;
      end else begin
         fsm_q        <= fsm_d;
         lfsr_q       <= lfsr_d;
         refresh_q    <= refresh_d;
         retry_q      <= retry_d;
         play_prev_q  <= play_prev_d;
         occ_req_q    <= occ_req_d;
         occ_x_q      <= occ_x_d;
         occ_y_q      <= occ_y_d;
         food_x_q     <= food_x_d;
         food_y_q     <= food_y_d;
         food_valid_q <= food_valid_d;
         grow_q       <= grow_d;
         place_fail_q <= place_fail_d;
      end
   end

   assign occ_req    = occ_req_q;
   assign occ_x      = occ_x_q;
   assign occ_y      = occ_y_q;
   assign food_x     = food_x_q;
   assign food_y     = food_y_q;
   assign food_valid = food_valid_q;
   assign grow       = grow_q;
   assign place_fail = place_fail_q;

endmodule

// File: tb/tb_food_placer.sv
// Bench for food_placer: occupancy-store responder with random latency/hits and a
// cycle-indexed LFSR table predicting every queried candidate.
module tb_food_placer;

   localparam int REFRESH = 200;
   localparam int RETRY   = 16;
   localparam int SEQ_N   = 8192;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [1:0] state = 2'b00;
   logic       tick = 1'b0;
   logic [5:0] head_x = 6'd0, head_y = 6'd0;
   logic       occ_req;
   logic [5:0] occ_x, occ_y;
   logic       occ_ack = 1'b0, occ_hit = 1'b0;
   logic [5:0] food_x, food_y;
   logic       food_valid, grow, place_fail;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   food_placer #(.REFRESH_TICKS(REFRESH), .MAX_RETRY(RETRY)) dut (
      .clk(clk), .rst(rst), .state(state), .tick(tick),
      .head_x(head_x), .head_y(head_y),
      .occ_req(occ_req), .occ_x(occ_x), .occ_y(occ_y),
      .occ_ack(occ_ack), .occ_hit(occ_hit),
      .food_x(food_x), .food_y(food_y), .food_valid(food_valid),
      .grow(grow), .place_fail(place_fail)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $display("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
         $error("check %s", tag);
      end
   endtask

   // Reference LFSR sequence: entry k is the register value after k clocks from reset.
   logic [15:0] seq [SEQ_N];

   function automatic int cx(input logic [15:0] v);
      return int'(v & 16'h003F) % 38 + 1;
   endfunction

   function automatic int cy(input logic [15:0] v);
      return int'((v >> 6) & 16'h003F) % 28 + 1;
   endfunction

   int cyc;
   always @(posedge clk or negedge rst) begin
      if (!rst) cyc <= 0;
      else      cyc <= cyc + 1;
   end

   // Occupancy store model
   int ack_delay = 0, hits_left = 0, nq = 0, req_age = 0;
   int exp_qx = 0, exp_qy = 0, last_qx = 0, last_qy = 0;
   bit resp_en = 1'b0, force_ack = 1'b0, req_prev = 1'b0, ack_live = 1'b0;

   always @(negedge clk) begin
      #1;
      if (!rst) begin
         occ_ack = 1'b0; occ_hit = 1'b0;
         req_prev = 1'b0; ack_live = 1'b0; req_age = 0;
      end else begin
         if (ack_live) begin
            nq++;
            last_qx = exp_qx; last_qy = exp_qy;
            if (occ_hit) hits_left--;
         end
         if (occ_req && !req_prev) begin
            exp_qx = (cyc >= 1 && cyc <= SEQ_N) ? cx(seq[cyc-1]) : -1;
            exp_qy = (cyc >= 1 && cyc <= SEQ_N) ? cy(seq[cyc-1]) : -1;
            req_age = 0;
            check("query_x", 32'(occ_x), exp_qx);
            check("query_y", 32'(occ_y), exp_qy);
         end else if (occ_req) begin
            check("query_hold", {20'd0, occ_x, occ_y}, {20'd0, exp_qx[5:0], exp_qy[5:0]});
         end
         ack_live = resp_en && occ_req && (req_age >= ack_delay);
         occ_ack  = ack_live || force_ack;
         occ_hit  = ack_live && (hits_left > 0);
         if (occ_req) req_age++;
         req_prev = occ_req;
      end
   end

   int wn, wpf, wgr;

   task automatic wait_food();
      wn = 0; wpf = 0; wgr = 0;
      do begin
         @(negedge clk);
         wn++;
         wpf += int'(place_fail);
         wgr += int'(grow);
      end while (!food_valid && wn < 400);
      check("food_commit_seen", 32'(food_valid), 1);
   endtask

   task automatic check_food_placed(input string tag);
      check({tag, "_x_range"}, 32'(food_x >= 6'd1 && food_x <= 6'd38), 1);
      check({tag, "_y_range"}, 32'(food_y >= 6'd1 && food_y <= 6'd28), 1);
      check({tag, "_x_is_miss"}, 32'(food_x), last_qx);
      check({tag, "_y_is_miss"}, 32'(food_y), last_qy);
   endtask

   task automatic eat(input bit keep_head);
      head_x = food_x; head_y = food_y;
      @(negedge clk);
      check("eat_grow", 32'(grow), 1);
      check("eat_valid_drop", 32'(food_valid), 0);
      if (!keep_head) begin head_x = 6'd0; head_y = 6'd0; end
   endtask

   task automatic tick_pulses(input int k);
      for (int i = 0; i < k; i++) begin
         tick = 1'b1; @(negedge clk);
         tick = 1'b0; @(negedge clk);
      end
   endtask

   task automatic wait_req();
      int n;
      n = 0;
      while (!occ_req && n < 20) begin @(negedge clk); n++; end
      check("query_open", 32'(occ_req), 1);
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_occ_req"}, 32'(occ_req), 0);
      check({tag, "_food_x"}, 32'(food_x), 10);
      check({tag, "_food_y"}, 32'(food_y), 20);
      check({tag, "_valid"}, 32'(food_valid), 0);
      check({tag, "_grow"}, 32'(grow), 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int fx0, fy0, fx, fy, nq0, hits;

      seq[0] = 16'hACE1;
      for (int i = 0; i < SEQ_N - 1; i++)
         seq[i+1] = {seq[i][14:0], ^(seq[i] & 16'hB400)};

      // Reset state
      repeat (3) @(negedge clk);
      check_idle_outputs("reset");
      check("reset_place_fail", 32'(place_fail), 0);
      check("reset_occ_x", 32'(occ_x), 0);
      check("reset_occ_y", 32'(occ_y), 0);

      // First placement with immediate misses
      state = 2'b01; resp_en = 1'b1; ack_delay = 0; hits_left = 0;
      @(negedge clk); rst = 1'b1;
      wait_food();
      $display("first commit after %0d cycles at (%0d,%0d)", wn, food_x, food_y);
      check("first_commit_latency", wn, 4);
      check_food_placed("first");
      fx0 = int'(food_x); fy0 = int'(food_y);

      // Eat with head parked on the old food cell
      fx = int'(food_x); fy = int'(food_y);
      eat(1'b1);
      @(negedge clk);
      check("grow_one_cycle", 32'(grow), 0);
      wait_food();
      $display("eat relocation to (%0d,%0d)", food_x, food_y);
      check("eat_no_extra_grow", wgr, 0);
      check("new_food_differs", 32'((int'(food_x) != fx) || (int'(food_y) != fy)), 1);
      check_food_placed("eat");
      head_x = 6'd0; head_y = 6'd0;

      // Sixteen consecutive hits exhaust the retry budget once
      hits_left = 16; nq0 = nq;
      eat(1'b0);
      wait_food();
      $display("16-hit relocation: queries=%0d place_fail=%0d", nq - nq0, wpf);
      check("retry_place_fail_count", wpf, 1);
      check("retry_query_count", nq - nq0, 17);
      check_food_placed("retry");

      // Random hit counts and ack latencies
      for (int r = 0; r < 5; r++) begin
         hits = int'($urandom_range(0, 20));
         ack_delay = int'($urandom_range(0, 3));
         hits_left = hits; nq0 = nq;
         eat(1'b0);
         wait_food();
         $display("random relocation %0d: hits=%0d delay=%0d queries=%0d place_fail=%0d",
                  r, hits, ack_delay, nq - nq0, wpf);
         check("rand_place_fail_count", wpf, hits / RETRY);
         check("rand_query_count", nq - nq0, hits + 1);
         check("rand_no_grow", wgr, 0);
         check_food_placed("rand");
      end
      ack_delay = 0;

      // Refresh after the configured tick count, no grow
      fx = int'(food_x); fy = int'(food_y);
      tick_pulses(REFRESH - 1);
      check("refresh_not_early", 32'(food_valid), 1);
      check("refresh_food_kept", {26'd0, food_x}, fx);
      tick = 1'b1; @(negedge clk); tick = 1'b0;
      check("refresh_valid_drop", 32'(food_valid), 0);
      check("refresh_no_grow", 32'(grow), 0);
      nq0 = nq;
      wait_food();
      $display("refresh relocation to (%0d,%0d)", food_x, food_y);
      check("refresh_wait_no_grow", wgr, 0);
      check("refresh_single_query", nq - nq0, 1);
      check_food_placed("refresh");

      // Eat on the same cycle as the final refresh tick
      @(negedge clk);
      tick_pulses(REFRESH - 1);
      tick = 1'b1; head_x = food_x; head_y = food_y;
      @(negedge clk);
      tick = 1'b0;
      check("eat_refresh_grow", 32'(grow), 1);
      check("eat_refresh_valid_drop", 32'(food_valid), 0);
      head_x = 6'd0; head_y = 6'd0;
      nq0 = nq;
      wait_food();
      fx = int'(food_x);
      repeat (12) @(negedge clk);
      $display("eat+refresh relocation: queries=%0d", nq - nq0);
      check("eat_refresh_single_query", nq - nq0, 1);
      check("eat_refresh_stays_valid", 32'(food_valid), 1);
      check("eat_refresh_food_kept", {26'd0, food_x}, fx);

      // Leave play during an open query; a late ack must be ignored
      resp_en = 1'b0;
      eat(1'b0);
      wait_req();
      state = 2'b00;
      @(negedge clk);
      check_idle_outputs("leave_play");
      @(negedge clk);
      force_ack = 1'b1;
      @(negedge clk);
      force_ack = 1'b0;
      repeat (3) @(negedge clk);
      check_idle_outputs("late_ack");
      $display("left play mid-query, late ack ignored");

      // Re-enter play
      state = 2'b01; resp_en = 1'b1;
      wait_food();
      check("reenter_latency", wn, 4);
      check_food_placed("reenter");

      // Reset asserted mid-query
      resp_en = 1'b0;
      eat(1'b0);
      wait_req();
      #3 rst = 1'b0;
      #1;
      check_idle_outputs("async_reset");
      check("async_reset_place_fail", 32'(place_fail), 0);
      check("async_reset_occ_x", 32'(occ_x), 0);
      check("async_reset_occ_y", 32'(occ_y), 0);
      @(negedge clk);
      @(negedge clk);
      resp_en = 1'b1; rst = 1'b1;
      wait_food();
      $display("post-reset commit after %0d cycles at (%0d,%0d)", wn, food_x, food_y);
      check("post_reset_latency", wn, 4);
      check("lfsr_restart_x", 32'(food_x), fx0);
      check("lfsr_restart_y", 32'(food_y), fy0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/food_placer.md
FOOD_PLACER -- requirements
Module: food_placer

Interface
REQ-001 SHALL have parameter REFRESH_TICKS, default 200: game ticks before an uneaten food item is relocated.
REQ-002 SHALL have parameter MAX_RETRY, default 16: consecutive rejected candidates before place_fail pulses.
REQ-003 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port state  input  2  game state; 2'b01 = PLAY, any other value = not playing.
REQ-006 SHALL have port tick  input  1  one-cycle game-step strobe.
REQ-007 SHALL have ports head_x / head_y  input  6 each  snake head cell.
REQ-008 SHALL have ports occ_req  output  1, occ_x / occ_y  output  6 each: occupancy query to the snake body store.
REQ-009 SHALL have ports occ_ack  input  1, occ_hit  input  1: query done; hit = cell is occupied by the body.
REQ-010 SHALL have ports food_x / food_y  output  6 each, food_valid  output  1: current food cell.
REQ-011 SHALL have ports grow  output  1 and place_fail  output  1: one-cycle pulses.

Function
REQ-012 SHALL hold a 16-bit Fibonacci LFSR with taps 16,14,13,11 and seed 16'hACE1 that advances every clk after reset, in all FSM states.
REQ-013 SHALL form each candidate as x = (lfsr[5:0] mod 38) + 1 and y = (lfsr[11:6] mod 28) + 1, so x is 1..38 and y is 1..28 (never a wall cell).
REQ-014 SHALL implement the FSM states IDLE, GEN, QUERY and COMMIT.
REQ-015 SHALL, in IDLE during PLAY, count tick pulses in the refresh counter.
REQ-016 SHALL, in GEN, latch the candidate; if it equals the head cell it is rejected in the same cycle (retry), otherwise the FSM goes to QUERY.
REQ-017 SHALL, in QUERY, drive occ_req=1 with occ_x/occ_y held at the candidate; occ_req and the address stay stable until the cycle in which occ_ack=1.
REQ-018 SHALL drop occ_req in the cycle after the ack; on occ_ack with occ_hit=1 the candidate is rejected and the FSM returns to GEN, and with occ_hit=0 the FSM goes to COMMIT.
REQ-019 SHALL, in COMMIT, load food_x/food_y with the candidate, set food_valid=1, clear the retry and refresh counters, and go to IDLE: one cycle.
REQ-020 SHALL detect eating when state=PLAY, food_valid=1 and head equals food: grow=1 for exactly one cycle, food_valid<=0, FSM to GEN.
REQ-021 SHALL detect refresh when the count reaches REFRESH_TICKS in IDLE: food_valid<=0, FSM to GEN, no grow.
REQ-022 SHALL, if eating and refresh occur in the same cycle, give eating priority: grow=1, refresh counter cleared.
REQ-023 SHALL count each rejection in the retry counter; on reaching MAX_RETRY, place_fail=1 for one cycle, the counter clears, and generation continues.
REQ-024 SHALL, when state goes from non-PLAY to PLAY, enter GEN on the next cycle.
REQ-025 SHALL, whenever state is not PLAY, from any FSM state: go to IDLE, force occ_req=0 (abandoning any open query, and ignoring a late ack), food=(10,20), food_valid=0, grow=0, and clear both counters.
REQ-026 SHALL latch head_x/head_y for eat detection every cycle with no added latency; grow is asserted in the cycle after the matching head is presented.

Reset
REQ-027 SHALL, while rst=0: food_x=10, food_y=20, food_valid=0, grow=0, place_fail=0, occ_req=0, occ_x=occ_y=0, lfsr=16'hACE1, FSM=IDLE, counters=0.
REQ-028 SHALL, if reset asserts mid-query, drop occ_req asynchronously, and a following ack SHALL have no effect.

Verification
REQ-029 SHALL cover: rst released, state=PLAY, occ_ack one cycle after every req with hit=0 -> food_valid=1 within 4 cycles, with food in x 1..38 and y 1..28.
REQ-030 SHALL cover: valid food at (F), head driven to F -> grow high for exactly 1 cycle, food_valid low, then new food committed at a position different from F.
REQ-031 SHALL cover: occ_hit=1 for 16 consecutive queries -> place_fail pulses once, occ_req keeps re-asserting, and the first miss commits.
REQ-032 SHALL cover: 200 ticks with no eat -> relocation with grow=0; and eat on the same cycle as the 200th tick -> grow=1 and a single relocation.
REQ-033 SHALL cover: state leaves PLAY while occ_req=1, ack arrives 2 cycles later -> occ_req=0 the next cycle, food=(10,20), food_valid=0, and the ack is ignored.
REQ-034 SHALL cover: rst pulsed low mid-QUERY -> all outputs at reset values immediately, and the LFSR sequence restarts identically.
